// File: rtl/game_pkg.sv
// Shared game types and constants: enemy AI state encoding and default tuning.
// Pure declarations; no logic, no latency, no flow control.
// Consumers import game_pkg::* and override the AI_* defaults through parameters.
package game_pkg;

    typedef enum logic [2:0] {
        AI_IDLE      = 3'd0,
        AI_MOVE_TO   = 3'd1,
        AI_MOVE_AWAY = 3'd2,
        AI_ATTACK    = 3'd3,
        AI_EVADE_J   = 3'd4,
        AI_EVADE_Q   = 3'd5,
        AI_GUARD     = 3'd6
    } ai_state_e;

    localparam int          AI_NEAR_DX      = 160;
    localparam int          AI_EVADE_DX     = 96;
    localparam int          AI_ATK_COOLDOWN = 4;
    localparam int          AI_DEF_HOLD     = 2;
    localparam logic [15:0] AI_LFSR_SEED    = 16'hACE1;
    localparam logic [15:0] AI_LFSR_MASK    = 16'hB400;

    // Magnitude of a 12-bit two's-complement distance; -2048 never occurs here.
    function automatic logic [11:0] abs12(input logic signed [11:0] v);
        logic [11:0] u;
        u = v;
        return v[11] ? (~u + 12'd1) : u;
    endfunction

endpackage

// File: rtl/ai_lfsr16.sv
// 16-bit Galois LFSR (right-shifting, feedback mask applied when bit 0 shifts out).
// Output is the registered state; advances one step per cycle with i_adv high.
// No backpressure: holds its value whenever i_adv is low.
module ai_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_adv,
    output logic [15:0] o_lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_adv) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? MASK : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_lfsr = lfsr_q;

endmodule

// File: rtl/enemy_ai_ctrl.sv
// Tick-paced enemy decision FSM: chase, retreat, attack, evade or guard from positions.
// Decisions every 2**TICK_DIV cycles; all outputs registered, pulses last one cycle.
// No backpressure: i_enable low forces IDLE and clears everything except the LFSR.
module enemy_ai_ctrl
    import game_pkg::*;
#(
    parameter int          TICK_DIV     = 7,
    parameter int          NEAR_DX      = AI_NEAR_DX,
    parameter int          EVADE_DX     = AI_EVADE_DX,
    parameter int          ATK_COOLDOWN = AI_ATK_COOLDOWN,
    parameter int          DEF_HOLD     = AI_DEF_HOLD,
    parameter logic [15:0] LFSR_SEED    = AI_LFSR_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic signed [10:0] i_player_x,
    input  logic signed [10:0] i_enemy_x,
    input  logic signed [10:0] i_goodbullet_x,
    input  logic               i_goodbullet_isE,
    input  logic               i_badbullet_isE,
    output logic               o_right,
    output logic               o_left,
    output logic               o_jump,
    output logic               o_squat,
    output logic               o_attack,
    output logic               o_defend,
    output logic [2:0]         o_state
);

    localparam int          CD_W    = $clog2(ATK_COOLDOWN + 1);
    localparam int          GD_W    = $clog2(DEF_HOLD + 1);
    localparam logic [11:0] NEAR_C  = 12'(NEAR_DX);
    localparam logic [11:0] EVADE_C = 12'(EVADE_DX);

    ai_state_e           state_q, state_d;
    logic [TICK_DIV-1:0] tick_cnt_q, tick_cnt_d;
    logic [CD_W-1:0]     atk_cd_q, atk_cd_d;
    logic [GD_W-1:0]     guard_cnt_q, guard_cnt_d;
    logic                right_q, right_d;
    logic                left_q, left_d;
    logic                jump_q, jump_d;
    logic                squat_q, squat_d;
    logic                attack_q, attack_d;
    logic                defend_q, defend_d;

    logic                tick;
    logic [15:0]         lfsr;
    logic signed [11:0]  dx;
    logic signed [11:0]  bd;
    logic [11:0]         adx;
    logic [11:0]         bdx;
    logic                near;
    logic                bullet_near;
    logic                dx_pos;
    logic                dx_neg;
    logic [CD_W-1:0]     cd_dec;

    assign tick = i_enable && (&tick_cnt_q);

    ai_lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (AI_LFSR_MASK)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_adv  (tick),
        .o_lfsr (lfsr)
    );

    assign dx          = $signed({i_player_x[10], i_player_x}) - $signed({i_enemy_x[10], i_enemy_x});
    assign bd          = $signed({i_goodbullet_x[10], i_goodbullet_x}) - $signed({i_enemy_x[10], i_enemy_x});
    assign adx         = abs12(dx);
    assign bdx         = abs12(bd);
    assign near        = (adx <= NEAR_C);
    assign bullet_near = i_goodbullet_isE && (bdx < EVADE_C);
    assign dx_neg      = dx[11];
    assign dx_pos      = !dx[11] && (dx != 12'sd0);

    // The cooldown step for this tick is taken before the attack test, so an
    // attack is allowed again exactly ATK_COOLDOWN ticks after the last one.
    assign cd_dec = (atk_cd_q == '0) ? '0 : atk_cd_q - CD_W'(1);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q + TICK_DIV'(1);
        atk_cd_d    = atk_cd_q;
        guard_cnt_d = guard_cnt_q;
        right_d     = right_q;
        left_d      = left_q;
        squat_d     = squat_q;
        defend_d    = defend_q;
        jump_d      = 1'b0;
        attack_d    = 1'b0;

        if (!i_enable) begin
            state_d     = AI_IDLE;
            tick_cnt_d  = '0;
            atk_cd_d    = '0;
            guard_cnt_d = '0;
            right_d     = 1'b0;
            left_d      = 1'b0;
            squat_d     = 1'b0;
            defend_d    = 1'b0;
        end else if (tick) begin
            atk_cd_d = cd_dec;

            if (state_q == AI_IDLE) begin
                state_d = AI_MOVE_TO;
            end else if (state_q == AI_GUARD && guard_cnt_q != '0) begin
                state_d     = AI_GUARD;
                guard_cnt_d = guard_cnt_q - GD_W'(1);
            end else if (bullet_near) begin
                if (lfsr[0]) begin
                    state_d     = AI_GUARD;
                    guard_cnt_d = GD_W'(DEF_HOLD - 1);
                end else if (lfsr[1]) begin
                    state_d = AI_EVADE_J;
                end else begin
                    state_d = AI_EVADE_Q;
                end
            end else if (cd_dec == '0 && !i_badbullet_isE && near) begin
                state_d  = AI_ATTACK;
                atk_cd_d = CD_W'(ATK_COOLDOWN);
            end else if (near && lfsr[3:2] == 2'b00) begin
                state_d = AI_MOVE_AWAY;
            end else begin
                state_d = AI_MOVE_TO;
            end

            // Entry outputs are recomputed on every tick, so re-entering a state re-fires its pulses.
            right_d  = 1'b0;
            left_d   = 1'b0;
            squat_d  = 1'b0;
            defend_d = 1'b0;
            case (state_d)
                AI_MOVE_TO: begin
                    right_d = dx_pos;
                    left_d  = dx_neg;
                    jump_d  = lfsr[4];
                end
                AI_MOVE_AWAY: begin
                    right_d = dx_neg;
                    left_d  = !dx_neg;
                end
                AI_ATTACK:  attack_d = 1'b1;
                AI_EVADE_J: jump_d   = 1'b1;
                AI_EVADE_Q: squat_d  = 1'b1;
                AI_GUARD:   defend_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= AI_IDLE;
            tick_cnt_q  <= '0;
            atk_cd_q    <= '0;
            guard_cnt_q <= '0;
            right_q     <= 1'b0;
            left_q      <= 1'b0;
            jump_q      <= 1'b0;
            squat_q     <= 1'b0;
            attack_q    <= 1'b0;
            defend_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            atk_cd_q    <= atk_cd_d;
            guard_cnt_q <= guard_cnt_d;
            right_q     <= right_d;
            left_q      <= left_d;
            jump_q      <= jump_d;
            squat_q     <= squat_d;
            attack_q    <= attack_d;
            defend_q    <= defend_d;
        end
    end

    assign o_right  = right_q;
    assign o_left   = left_q;
    assign o_jump   = jump_q;
    assign o_squat  = squat_q;
    assign o_attack = attack_q;
    assign o_defend = defend_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// Bench for enemy_ai_ctrl with an 8-cycle decision period: directed scenarios plus
// a long random run, all cycles compared against a tick-level reference model.
module tb_enemy_ai_ctrl;

    localparam int TD     = 3;
    localparam int PERIOD = 1 << TD;
    localparam int NEAR   = 160;
    localparam int EVADE  = 96;
    localparam int COOL   = 4;
    localparam int HOLD   = 2;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic signed [10:0] player_x;
    logic signed [10:0] enemy_x;
    logic signed [10:0] gbx;
    logic               gb;
    logic               bb;
    logic               o_right, o_left, o_jump, o_squat, o_attack, o_defend;
    logic [2:0]         o_state;

    enemy_ai_ctrl #(.TICK_DIV(TD)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_enable         (en),
        .i_player_x       (player_x),
        .i_enemy_x        (enemy_x),
        .i_goodbullet_x   (gbx),
        .i_goodbullet_isE (gb),
        .i_badbullet_isE  (bb),
        .o_right          (o_right),
        .o_left           (o_left),
        .o_jump           (o_jump),
        .o_squat          (o_squat),
        .o_attack         (o_attack),
        .o_defend         (o_defend),
        .o_state          (o_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks decision ticks and remembers when the last attack
    // and the last guard entry happened, instead of counting down per tick.
    int          m_state, m_cnt, m_ticks, m_last_atk, m_guard_entry;
    int unsigned m_lfsr;
    bit          e_r, e_l, e_j, e_q, e_a, e_d;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_ticks = 0;
        m_last_atk = -100; m_guard_entry = -100;
        m_lfsr = 32'hACE1;
        {e_r, e_l, e_j, e_q, e_a, e_d} = '0;
    endtask

    task automatic model_step();
        int px, ex, bx, dx, adx, bdx, nxt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_j = 0; e_a = 0;
        if (!en) begin
            m_state = 0; m_cnt = 0; m_ticks = 0; m_last_atk = -100;
            {e_r, e_l, e_q, e_d} = '0;
            return;
        end
        if (m_cnt != PERIOD - 1) begin
            m_cnt++;
            return;
        end
        m_cnt = 0;
        m_ticks++;
        px = player_x; ex = enemy_x; bx = gbx;
        dx  = px - ex;
        adx = (dx < 0) ? -dx : dx;
        bdx = (bx - ex < 0) ? ex - bx : bx - ex;
        if (m_state == 0)
            nxt = 1;
        else if (m_state == 6 && m_ticks < m_guard_entry + HOLD)
            nxt = 6;
        else if (gb && bdx < EVADE) begin
            if (m_lfsr % 2 == 1) begin
                nxt = 6;
                m_guard_entry = m_ticks;
            end else
                nxt = ((m_lfsr / 2) % 2 == 1) ? 4 : 5;
        end else if (m_ticks - m_last_atk >= COOL && !bb && adx <= NEAR) begin
            nxt = 3;
            m_last_atk = m_ticks;
        end else if (adx <= NEAR && (m_lfsr / 4) % 4 == 0)
            nxt = 2;
        else
            nxt = 1;
        {e_r, e_l, e_q, e_d} = '0;
        case (nxt)
            1: begin e_r = (dx > 0); e_l = (dx < 0); e_j = ((m_lfsr / 16) % 2 == 1); end
            2: begin e_r = (dx < 0); e_l = (dx >= 0); end
            3: e_a = 1;
            4: e_j = 1;
            5: e_q = 1;
            6: e_d = 1;
            default: ;
        endcase
        m_state = nxt;
        if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 32'hB400;
        else                 m_lfsr = m_lfsr / 2;
    endtask

    logic prev_attack = 1'b0;

    task automatic step();
        logic [8:0] got, exp;
        @(posedge clk);
        model_step();
        #1;
        got = {o_state, o_right, o_left, o_jump, o_squat, o_attack, o_defend};
        exp = {3'(m_state), e_r, e_l, e_j, e_q, e_a, e_d};
        check("cycle_vs_model", 32'(got), 32'(exp));
        check("inv_right_left", 32'(o_right & o_left), 0);
        check("inv_jump_squat", 32'(o_jump & o_squat), 0);
        check("inv_defend_guard", 32'(o_defend && o_state != 3'd6), 0);
        check("inv_attack_consec", 32'(o_attack & prev_attack), 0);
        prev_attack = o_attack;
    endtask

    task automatic rand_pos();
        int e;
        e = int'($urandom_range(0, 1400)) - 700;
        enemy_x  = 11'(e);
        player_x = 11'(e + int'($urandom_range(0, 500)) - 250);
        gbx      = 11'(e + int'($urandom_range(0, 240)) - 120);
    endtask

    task automatic wait_guard_rise(input string tag);
        logic prev;
        bit   seen;
        prev = o_defend;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            if (o_defend && !prev) seen = 1;
            prev = o_defend;
        end
        check(tag, 32'(seen), 1);
    endtask

    initial begin
        int k, natk, last, run, bad, dis;
        rst_n = 1'b0; en = 1'b0; gb = 1'b0; bb = 1'b0;
        player_x = 11'sd600; enemy_x = 11'sd100; gbx = 11'sd0;
        model_reset();
        #12;
        check("reset_outputs", 32'({o_state, o_right, o_left, o_jump, o_squat, o_attack, o_defend}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 50; i++) step();
        check("idle_state", 32'(o_state), 0);

        en = 1'b1;
        k = 0;
        for (int i = 1; i <= 100 && k == 0; i++) begin
            step();
            if (o_state == 3'd1) k = i;
        end
        check("first_decision_latency", 32'(k), 8);

        check("chase_right", 32'({o_right, o_left}), 32'b10);
        player_x = 11'sd100; enemy_x = 11'sd600;
        run = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (o_right && !o_left) run++;
        end
        check("chase_hold_cycles", 32'(run), 8);
        step();
        check("chase_swapped_left", 32'({o_right, o_left}), 32'b01);

        player_x = 11'sd200; enemy_x = 11'sd100;
        natk = 0; last = -1;
        for (int i = 0; i < 20 * PERIOD; i++) begin
            step();
            if (o_attack) begin
                if (last >= 0) check("attack_gap", 32'(i - last), 32'(COOL * PERIOD));
                last = i;
                natk++;
            end
        end
        check("attack_count", 32'(natk), 5);

        player_x = 11'sd150; bb = 1'b1;
        natk = 0; bad = 0;
        for (int i = 0; i < 10 * PERIOD; i++) begin
            step();
            if (o_attack) natk++;
            if (o_state != 3'd1 && o_state != 3'd2) bad++;
        end
        check("blocked_attacks", 32'(natk), 0);
        check("blocked_states", 32'(bad), 0);

        bb = 1'b0; player_x = 11'sd600; enemy_x = 11'sd100; gbx = 11'sd140; gb = 1'b1;
        wait_guard_rise("guard_entered");
        gb = 1'b0;
        run = 1;
        for (int i = 0; i < 40 && o_defend; i++) begin
            step();
            if (o_defend) run++;
        end
        check("guard_hold_cycles", 32'(run), HOLD * PERIOD);

        gb = 1'b1;
        wait_guard_rise("guard_entered_again");
        en = 1'b0;
        step();
        check("disable_defend", 32'(o_defend), 0);
        check("disable_state", 32'(o_state), 0);
        gb = 1'b0; player_x = 11'sd200; enemy_x = 11'sd100; en = 1'b1;
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            step();
            if (o_attack) k = i;
        end
        check("reenable_attack_cycle", 32'(k), 2 * PERIOD);

        dis = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) rand_pos();
            if ($urandom_range(0, 19) == 0) gb = ~gb;
            if ($urandom_range(0, 19) == 0) bb = ~bb;
            if (dis > 0) begin
                dis--;
                en = (dis == 0);
            end else if ($urandom_range(0, 799) == 0) begin
                dis = int'($urandom_range(1, 20));
                en = 1'b0;
            end
            if (i == 5003) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check("midrun_reset", 32'({o_state, o_right, o_left, o_jump, o_squat, o_attack, o_defend}), 0);
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_ai_ctrl.md
Name: enemy_ai_ctrl

Overview:
Decision scheduler that drives the Enemy movement block and the enemy-side BadBullet. It replaces free-running random enemy inputs with a tick-paced state machine. The state machine reads player, enemy and bullet positions and chooses chase, retreat, attack, evade or guard actions. Sits inside GameControl between the game-state FSM (i_enable = playing) and the enemy/badbullet instances.

Parameters:
TICK_DIV, 7, decision period = 2**TICK_DIV clk cycles
NEAR_DX, 160, |dx| at or below which the enemy may attack or retreat
EVADE_DX, 96, |goodbullet_x - enemy_x| below which an in-flight player bullet triggers evasion
ATK_COOLDOWN, 4, decision ticks blocked after an attack
DEF_HOLD, 2, decision ticks a guard is held
LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR (must be nonzero)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  high while the game is in the PLAY state
i_player_x  in  11 signed  player x
i_enemy_x  in  11 signed  enemy x
i_goodbullet_x  in  11 signed  player bullet x
i_goodbullet_isE  in  1  player bullet in flight
i_badbullet_isE  in  1  enemy bullet in flight
o_right  out  1  enemy move-right level
o_left  out  1  enemy move-left level
o_jump  out  1  enemy jump, single-cycle pulse
o_squat  out  1  enemy squat level
o_attack  out  1  enemy fire, single-cycle pulse
o_defend  out  1  enemy shield level
o_state  out  3  current FSM state, for debug

Behaviour:
- Reset and interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- On reset: state = IDLE, all outputs = 0, tick_cnt = 0, atk_cd = 0, guard_cnt = 0, lfsr = LFSR_SEED.
- State encoding: IDLE = 0, MOVE_TO = 1, MOVE_AWAY = 2, ATTACK = 3, EVADE_J = 4, EVADE_Q = 5, GUARD = 6.
- All outputs are registered.
- tick_cnt (TICK_DIV bits) increments every cycle while i_enable=1. tick = (tick_cnt == all-ones).
- Each tick: lfsr advances as a Galois LFSR, mask 16'hB400. atk_cd decrements, saturating at 0.
- i_enable = 0 (synchronous, any state): next cycle state = IDLE, all outputs 0, tick_cnt = 0, atk_cd = 0, guard_cnt = 0. lfsr holds its value.
- IDLE -> MOVE_TO on the first tick after i_enable rises. The first decision therefore occurs 2**TICK_DIV cycles after enable.
- Arithmetic:
  - dx = i_player_x - i_enemy_x, computed at 12-bit signed width.
  - adx = |dx|.
  - bdx = |i_goodbullet_x - i_enemy_x|, also 12-bit.
  - No overflow is possible at these widths.
- Decision at each tick, evaluated in priority order:
  1. Current state is GUARD and guard_cnt != 0: stay in GUARD, guard_cnt--.
  2. i_goodbullet_isE and bdx < EVADE_DX: if lfsr[0]=1 go to GUARD (guard_cnt = DEF_HOLD-1). Otherwise go to EVADE_J if lfsr[1]=1, else EVADE_Q.
  3. atk_cd == 0 and !i_badbullet_isE and adx <= NEAR_DX: go to ATTACK, atk_cd = ATK_COOLDOWN.
  4. adx <= NEAR_DX and lfsr[3:2] == 0: go to MOVE_AWAY.
  5. Otherwise: go to MOVE_TO.
- Outputs are set on the state-entry cycle and held until the next tick:
  - MOVE_TO: o_right = (dx > 0), o_left = (dx < 0). When dx == 0, both are 0. If lfsr[4] = 1, o_jump pulses for 1 cycle on entry.
  - MOVE_AWAY: direction opposite to MOVE_TO. When dx == 0, move left.
  - ATTACK: o_attack = 1 for exactly 1 cycle on entry. o_right, o_left, o_defend are 0.
  - EVADE_J: o_jump = 1 for 1 cycle on entry.
  - EVADE_Q: o_squat held for the whole period.
  - GUARD: o_defend held for the whole period, and for every consecutive GUARD period. Movement outputs are 0.
  - Outputs not named for a state are 0.
- Invariants:
  - o_right & o_left never both 1.
  - o_jump & o_squat never both 1.
  - o_defend = 1 only in GUARD.
  - o_attack is never high on consecutive cycles.
- Re-entering the same state on a tick re-fires its entry pulses. For example, MOVE_TO -> MOVE_TO with lfsr[4] = 1 jumps again.
- Reset mid-period: immediate return to the reset values; no residual pulse.

Decomposition:
- game_pkg gains:
  - ai_state_e, a 3-bit enum with the encoding above;
  - default constants AI_NEAR_DX, AI_EVADE_DX, AI_ATK_COOLDOWN, AI_DEF_HOLD.
- One sub-module, ai_lfsr16: parameterised seed and advance enable, 16-bit output. It is reusable by other randomised blocks.
- The FSM, counters and distance arithmetic stay in enemy_ai_ctrl.

Test Plan:
- Reset / idle: TICK_DIV = 3, i_enable = 0 for 50 cycles -> all outputs 0, o_state = 0. Raise i_enable -> o_state = 1 exactly 8 cycles later.
- Chase: player_x = 600, enemy_x = 100, no bullets -> MOVE_TO, o_right = 1, o_left = 0 held for 8 cycles. Swap positions -> o_left = 1 on the next decision.
- Attack and cooldown: player_x = 200, enemy_x = 100, badbullet_isE = 0 -> o_attack is a single 1-cycle pulse. With ATK_COOLDOWN = 4, there is no further attack for the next 3 ticks; an attack is allowed at the 4th tick.
- Attack blocked: adx = 50, i_badbullet_isE = 1 -> never ATTACK; only MOVE_TO / MOVE_AWAY.
- Evade / guard: goodbullet_isE = 1, goodbullet_x = enemy_x + 40 -> next state in {GUARD, EVADE_J, EVADE_Q} as chosen by the lfsr bits. When GUARD is chosen, o_defend = 1 continuously for DEF_HOLD × 8 = 16 cycles even if the bullet vanishes.
- Disable mid-action: drop i_enable while in GUARD -> next cycle o_defend = 0 and o_state = 0. Re-enable -> atk_cd = 0, so an attack is possible at the first eligible tick. Across a 10k-cycle random-position run, the invariants hold every cycle.
